// File: rtl/mod_mapper_pkg.sv
// mod_mapper_pkg: scheme codes, Qm lookup and FSM state type for the modulation mapper controller.
package mod_mapper_pkg;
   localparam logic [1:0] SCH_QPSK   = 2'd0;
   localparam logic [1:0] SCH_16QAM  = 2'd1;
   localparam logic [1:0] SCH_64QAM  = 2'd2;
   localparam logic [1:0] SCH_256QAM = 2'd3;

   typedef enum logic [1:0] {IDLE, COLLECT, MAP, OUT} state_t;

   function automatic logic [3:0] qm_of(input logic [1:0] s);
      return {1'b0, s, 1'b0} + 4'd2;
   endfunction
endpackage

// File: rtl/mod_bit_collector.sv
// mod_bit_collector: MSB-first shift register and bit counter filling the Qm-wide LUT field.
module mod_bit_collector (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] Qm,
   input  logic       accept,
   input  logic       clear,
   input  logic       bit_in,
   output logic       full,
   output logic [7:0] LUT_Bits
);
   logic [3:0] cnt;

   // asserted on the accept that completes the field, so the FSM leaves COLLECT on that same edge
   assign full = accept && (cnt == Qm - 4'd1);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt      <= '0;
         LUT_Bits <= '0;
      end else if (accept) begin
         cnt      <= cnt + 4'd1;
         LUT_Bits <= {LUT_Bits[6:0], bit_in};
      end
   end
endmodule

// File: rtl/mod_mapper_ctrl.sv
// mod_mapper_ctrl: collects Qm serial bits per symbol, pulses the LUT enable and hands the symbol downstream.
// Define MOD_MAPPER_256QAM_EN to make scheme 3 (256QAM) legal.
module mod_mapper_ctrl
   import mod_mapper_pkg::*;
#(
   parameter int LUT_WIDTH = 18,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 Start,
   input  logic                 Abort,
   input  logic [1:0]           Mod_Scheme,
   input  logic [CNT_WIDTH-1:0] Num_Symbols,
   input  logic                 Bit_In,
   input  logic                 Bit_Valid,
   output logic                 Bit_Ready,
   output logic [7:0]           LUT_Bits,
   output logic                 EN_QPSK,
   output logic                 EN_16QAM,
   output logic                 EN_64QAM,
   output logic                 EN_256QAM,
   output logic                 Sym_Valid,
   input  logic                 Sym_Ready,
   output logic                 Busy,
   output logic                 Done,
   output logic                 Err,
   output logic [CNT_WIDTH-1:0] Sym_Cnt
);
`ifdef MOD_MAPPER_256QAM_EN
   localparam logic QAM256 = 1'b1;
`else
   localparam logic QAM256 = 1'b0;
`endif

   if (LUT_WIDTH < 1) begin : g_bad_width
      $error("LUT_WIDTH must be positive");
   end

   state_t               state;
   logic [1:0]           scheme_q;
   logic [CNT_WIDTH-1:0] num_q;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic [3:0]           en;
   logic                 full;
   logic                 accept;
   logic                 clear;
   logic                 illegal;

   assign accept    = Bit_Valid & Bit_Ready;
   assign clear     = Abort | (state == IDLE) | (state == OUT & Sym_Ready);
   assign illegal   = (Mod_Scheme == SCH_256QAM) && !QAM256;
   assign cnt_inc   = Sym_Cnt + CNT_WIDTH'(1);
   assign Busy      = state != IDLE;
   assign EN_QPSK   = en[0];
   assign EN_16QAM  = en[1];
   assign EN_64QAM  = en[2];
   assign EN_256QAM = en[3] & QAM256;

   mod_bit_collector u_collector (
      .clk      (CLK),
      .rst      (RST),
      .Qm       (qm_of(scheme_q)),
      .accept   (accept),
      .clear    (clear),
      .bit_in   (Bit_In),
      .full     (full),
      .LUT_Bits (LUT_Bits)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         scheme_q  <= SCH_QPSK;
         num_q     <= '0;
         Bit_Ready <= 1'b0;
         en        <= '0;
         Sym_Valid <= 1'b0;
         Done      <= 1'b0;
         Err       <= 1'b0;
         Sym_Cnt   <= '0;
      end else if (Abort) begin
         state     <= IDLE;
         Bit_Ready <= 1'b0;
         en        <= '0;
         Sym_Valid <= 1'b0;
         Done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               Done <= 1'b0;
               if (Start) begin
                  if (illegal) Err <= 1'b1;
                  else if (Num_Symbols == '0) Done <= 1'b1;
                  else begin
                     scheme_q  <= Mod_Scheme;
                     num_q     <= Num_Symbols;
                     Sym_Cnt   <= '0;
                     Bit_Ready <= 1'b1;
                     state     <= COLLECT;
                  end
               end
            end
            COLLECT: if (full) begin
               Bit_Ready <= 1'b0;
               en        <= 4'b0001 << scheme_q;
               state     <= MAP;
            end
            MAP: begin
               en        <= '0;
               Sym_Valid <= 1'b1;
               state     <= OUT;
            end
            OUT: if (Sym_Ready) begin
               Sym_Valid <= 1'b0;
               Sym_Cnt   <= cnt_inc;
               if (cnt_inc == num_q) begin
                  Done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  Bit_Ready <= 1'b1;
                  state     <= COLLECT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mod_mapper_ctrl.sv
// tb_mod_mapper_ctrl: directed self-checking bench for mod_mapper_ctrl.
module tb_mod_mapper_ctrl;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        Start = 1'b0;
   logic        Abort = 1'b0;
   logic [1:0]  Mod_Scheme = '0;
   logic [15:0] Num_Symbols = '0;
   logic        Bit_In = 1'b0;
   logic        Bit_Valid = 1'b0;
   logic        Sym_Ready = 1'b0;
   logic        Bit_Ready, EN_QPSK, EN_16QAM, EN_64QAM, EN_256QAM;
   logic        Sym_Valid, Busy, Done, Err;
   logic [7:0]  LUT_Bits;
   logic [15:0] Sym_Cnt;
   int          checks = 0;
   int          errors = 0;

   mod_mapper_ctrl dut (
      .CLK(CLK), .RST(RST), .Start(Start), .Abort(Abort),
      .Mod_Scheme(Mod_Scheme), .Num_Symbols(Num_Symbols),
      .Bit_In(Bit_In), .Bit_Valid(Bit_Valid), .Bit_Ready(Bit_Ready),
      .LUT_Bits(LUT_Bits), .EN_QPSK(EN_QPSK), .EN_16QAM(EN_16QAM),
      .EN_64QAM(EN_64QAM), .EN_256QAM(EN_256QAM), .Sym_Valid(Sym_Valid),
      .Sym_Ready(Sym_Ready), .Busy(Busy), .Done(Done), .Err(Err), .Sym_Cnt(Sym_Cnt)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      Bit_Valid = 1'b1;
      Bit_In    = b;
      tick();
      Bit_Valid = 1'b0;
   endtask

   task automatic start_block(input logic [1:0] s, input logic [15:0] n);
      Mod_Scheme  = s;
      Num_Symbols = n;
      Start       = 1'b1;
      tick();
      Start       = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++;
      if ({Bit_Ready, LUT_Bits, EN_QPSK, EN_16QAM, EN_64QAM, EN_256QAM, Sym_Valid, Busy, Done, Err, Sym_Cnt} !== 33'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0", {Bit_Ready, LUT_Bits, EN_QPSK, EN_16QAM, EN_64QAM, EN_256QAM, Sym_Valid, Busy, Done, Err, Sym_Cnt});
      end
      RST = 1'b0;
      tick();
   endtask

   task automatic test_qpsk();
      Sym_Ready = 1'b1;
      start_block(2'd0, 16'd2);
      checks++;
      if ({Busy, Bit_Ready, Sym_Cnt} !== {1'b1, 1'b1, 16'd0}) begin
         errors++;
         $display("FAIL qpsk_start got %b%b %0d want 11 0", Busy, Bit_Ready, Sym_Cnt);
      end
      Start = 1'b1; Mod_Scheme = 2'd1; Num_Symbols = 16'd7;
      drive_bit(1'b1);
      Start = 1'b0;
      drive_bit(1'b0);
      checks++;
      if ({EN_QPSK, EN_16QAM, Bit_Ready, Sym_Valid, LUT_Bits} !== {4'b1000, 8'h02}) begin
         errors++;
         $display("FAIL qpsk_map0 got %b %h want 1000 02", {EN_QPSK, EN_16QAM, Bit_Ready, Sym_Valid}, LUT_Bits);
      end
      tick();
      checks++;
      if ({EN_QPSK, Sym_Valid, LUT_Bits} !== {2'b01, 8'h02}) begin
         errors++;
         $display("FAIL qpsk_out0 got %b %h want 01 02", {EN_QPSK, Sym_Valid}, LUT_Bits);
      end
      tick();
      checks++;
      if ({Sym_Cnt, Bit_Ready, Sym_Valid, Done} !== {16'd1, 3'b100}) begin
         errors++;
         $display("FAIL qpsk_hs0 got %0d %b want 1 100", Sym_Cnt, {Bit_Ready, Sym_Valid, Done});
      end
      drive_bit(1'b1);
      drive_bit(1'b1);
      checks++;
      if ({EN_QPSK, LUT_Bits} !== {1'b1, 8'h03}) begin
         errors++;
         $display("FAIL qpsk_map1 got %b %h want 1 03", EN_QPSK, LUT_Bits);
      end
      tick();
      tick();
      checks++;
      if ({Done, Busy, Sym_Cnt} !== {2'b10, 16'd2}) begin
         errors++;
         $display("FAIL qpsk_done got %b %0d want 10 2", {Done, Busy}, Sym_Cnt);
      end
      tick();
      checks++;
      if ({Done, Sym_Cnt} !== {1'b0, 16'd2}) begin
         errors++;
         $display("FAIL qpsk_hold got %b %0d want 0 2", Done, Sym_Cnt);
      end
      Sym_Ready = 1'b0;
   endtask

   task automatic test_16qam();
      logic [3:0] pat = 4'b1101;
      start_block(2'd1, 16'd1);
      for (int i = 3; i >= 0; i--) begin
         Bit_Valid = 1'b0;
         tick();
         drive_bit(pat[i]);
      end
      checks++;
      if ({EN_16QAM, EN_QPSK, EN_64QAM, Sym_Valid, LUT_Bits} !== {4'b1000, 8'h0D}) begin
         errors++;
         $display("FAIL q16_map got %b %h want 1000 0d", {EN_16QAM, EN_QPSK, EN_64QAM, Sym_Valid}, LUT_Bits);
      end
      tick();
      checks++;
      if ({EN_16QAM, Sym_Valid, LUT_Bits} !== {2'b01, 8'h0D}) begin
         errors++;
         $display("FAIL q16_out got %b %h want 01 0d", {EN_16QAM, Sym_Valid}, LUT_Bits);
      end
      Sym_Ready = 1'b1;
      tick();
      checks++;
      if ({Done, Busy, Sym_Cnt} !== {2'b10, 16'd1}) begin
         errors++;
         $display("FAIL q16_done got %b %0d want 10 1", {Done, Busy}, Sym_Cnt);
      end
      Sym_Ready = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      start_block(2'd0, 16'd2);
      drive_bit(1'b0);
      drive_bit(1'b1);
      tick();
      Bit_Valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({Sym_Valid, Bit_Ready, LUT_Bits, Sym_Cnt} !== {2'b10, 8'h01, 16'd0}) begin
            errors++;
            $display("FAIL bp_hold%0d got %b %h %0d want 10 01 0", i, {Sym_Valid, Bit_Ready}, LUT_Bits, Sym_Cnt);
         end
         tick();
      end
      Bit_Valid = 1'b0;
      Sym_Ready = 1'b1;
      tick();
      checks++;
      if ({Sym_Cnt, Sym_Valid, Bit_Ready, Done} !== {16'd1, 3'b010}) begin
         errors++;
         $display("FAIL bp_release got %0d %b want 1 010", Sym_Cnt, {Sym_Valid, Bit_Ready, Done});
      end
      Sym_Ready = 1'b0;
      Abort = 1'b1;
      tick();
      Abort = 1'b0;
      checks++;
      if ({Busy, Done, Bit_Ready} !== 3'b000) begin
         errors++;
         $display("FAIL bp_abort got %b want 000", {Busy, Done, Bit_Ready});
      end
   endtask

   task automatic test_abort();
      logic [5:0] pat = 6'b110010;
      start_block(2'd2, 16'd1);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      Abort = 1'b1;
      tick();
      Abort = 1'b0;
      checks++;
      if ({Busy, Bit_Ready, Done, LUT_Bits} !== 11'd0) begin
         errors++;
         $display("FAIL abort_idle got %b %h want 000 00", {Busy, Bit_Ready, Done}, LUT_Bits);
      end
      tick();
      checks++;
      if (Done !== 1'b0) begin
         errors++;
         $display("FAIL abort_nodone got %b want 0", Done);
      end
      Start = 1'b1;
      Abort = 1'b1;
      tick();
      Start = 1'b0;
      Abort = 1'b0;
      checks++;
      if ({Busy, Done} !== 2'b00) begin
         errors++;
         $display("FAIL abort_wins got %b want 00", {Busy, Done});
      end
      start_block(2'd2, 16'd1);
      for (int i = 5; i >= 0; i--) drive_bit(pat[i]);
      checks++;
      if ({EN_64QAM, LUT_Bits} !== {1'b1, 8'h32}) begin
         errors++;
         $display("FAIL abort_restart got %b %h want 1 32", EN_64QAM, LUT_Bits);
      end
      Sym_Ready = 1'b1;
      tick();
      tick();
      checks++;
      if ({Done, Sym_Cnt} !== {1'b1, 16'd1}) begin
         errors++;
         $display("FAIL abort_done got %b %0d want 1 1", Done, Sym_Cnt);
      end
      Sym_Ready = 1'b0;
      tick();
   endtask

   task automatic test_zero_and_err();
      start_block(2'd0, 16'd0);
      checks++;
      if ({Done, Busy} !== 2'b10) begin
         errors++;
         $display("FAIL zero_done got %b want 10", {Done, Busy});
      end
      tick();
      checks++;
      if ({Done, Busy} !== 2'b00) begin
         errors++;
         $display("FAIL zero_pulse got %b want 00", {Done, Busy});
      end
`ifndef MOD_MAPPER_256QAM_EN
      start_block(2'd3, 16'd1);
      checks++;
      if ({Err, Busy, Done, EN_QPSK, EN_16QAM, EN_64QAM, EN_256QAM} !== 7'b1000000) begin
         errors++;
         $display("FAIL err_set got %b want 1000000", {Err, Busy, Done, EN_QPSK, EN_16QAM, EN_64QAM, EN_256QAM});
      end
      Abort = 1'b1;
      tick();
      Abort = 1'b0;
      tick();
      checks++;
      if ({Err, Busy, EN_256QAM} !== 3'b100) begin
         errors++;
         $display("FAIL err_sticky got %b want 100", {Err, Busy, EN_256QAM});
      end
`else
      begin
         logic [7:0] p8 = 8'hA5;
         start_block(2'd3, 16'd1);
         for (int i = 7; i >= 0; i--) drive_bit(p8[i]);
         checks++;
         if ({Err, EN_256QAM, LUT_Bits} !== {2'b01, 8'hA5}) begin
            errors++;
            $display("FAIL q256_map got %b %h want 01 a5", {Err, EN_256QAM}, LUT_Bits);
         end
         Abort = 1'b1;
         tick();
         Abort = 1'b0;
      end
`endif
      start_block(2'd0, 16'd1);
      drive_bit(1'b1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      checks++;
      if ({Bit_Ready, LUT_Bits, EN_QPSK, EN_16QAM, EN_64QAM, EN_256QAM, Sym_Valid, Busy, Done, Err, Sym_Cnt} !== 33'd0) begin
         errors++;
         $display("FAIL rst_midblock got %h want 0", {Bit_Ready, LUT_Bits, EN_QPSK, EN_16QAM, EN_64QAM, EN_256QAM, Sym_Valid, Busy, Done, Err, Sym_Cnt});
      end
   endtask

   initial begin
      test_reset();
      test_qpsk();
      test_16qam();
      test_backpressure();
      test_abort();
      test_zero_and_err();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
